// File: rtl/jtframe_mist_spi_tx.sv
// SPI master that frames a ROM download as the data_io file-transfer command
// sequence: index, start, data (header + payload stream) and end transactions.
module jtframe_mist_spi_tx #(
    parameter int CLKDIV = 4,
    parameter int SS_GAP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic [25:0] len,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic [25:0] sent_cnt,
    output logic        spi_sck,
    output logic        spi_ss2,
    output logic        spi_di
);
    localparam int CMAX = (CLKDIV > SS_GAP) ? CLKDIV : SS_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_M1 = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(SS_GAP - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [2:0] {IDLE, SSLEAD, LOAD, SHIFT, SSTRAIL, GAP, FIN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_phase;
    logic          r_bsel;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
    logic [7:0]    r_index;
    logic [25:0]   r_len;
    logic [25:0]   r_sent_cnt;
    logic          r_sck, r_ss2, r_di, r_busy, r_done;

    logic          w_pay;
    logic          w_last;
    logic [7:0]    w_byte;

    // r_bsel=0 selects the command byte of a phase, 1 its argument/payload
    assign w_pay      = (r_phase == 2'd2) && r_bsel;
    assign byte_ready = (r_state == LOAD) && w_pay && byte_valid;
    assign w_last     = r_bsel ? ((r_phase != 2'd2) || (r_sent_cnt + 26'd1 == r_len))
                               : ((r_phase == 2'd2) && (r_len == 26'd0));

    always_comb begin
        w_byte = 8'h00;
        case (r_phase)
            2'd0:    w_byte = r_bsel ? r_index   : 8'h55;
            2'd1:    w_byte = r_bsel ? 8'hFF     : 8'h53;
            2'd2:    w_byte = r_bsel ? byte_data : 8'h54;
            default: w_byte = r_bsel ? 8'h00     : 8'h53;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_phase    <= 2'd0;
            r_bsel     <= 1'b0;
            r_bit      <= 3'd0;
            r_sh       <= 8'h00;
            r_index    <= 8'h00;
            r_len      <= 26'd0;
            r_sent_cnt <= 26'd0;
            r_sck      <= 1'b0;
            r_ss2      <= 1'b1;
            r_di       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_index    <= index;
                    r_len      <= len;
                    r_sent_cnt <= 26'd0;
                    r_busy     <= 1'b1;
                    r_phase    <= 2'd0;
                    r_bsel     <= 1'b0;
                    r_ss2      <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= SSLEAD;
                end
                // SSLEAD and LOAD count toward the first low half, so SS leads SCK by CLKDIV
                SSLEAD: begin
                    r_cnt   <= ONE;
                    r_state <= LOAD;
                end
                LOAD: if (!w_pay || byte_valid) begin
                    r_sh    <= w_byte;
                    r_di    <= w_byte[7];
                    r_bit   <= 3'd7;
                    r_state <= SHIFT;
                    if (r_cnt == DIV_M1) begin
                        r_sck <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                SHIFT: if (r_cnt == DIV_M1) begin
                    r_cnt <= '0;
                    if (!r_sck) begin
                        r_sck <= 1'b1;
                    end else begin
                        r_sck <= 1'b0;
                        if (r_bit == 3'd0) begin
                            if (w_pay) r_sent_cnt <= r_sent_cnt + 26'd1;
                            r_bsel  <= 1'b1;
                            r_state <= w_last ? SSTRAIL : LOAD;
                        end else begin
                            r_bit <= r_bit - 3'd1;
                            r_di  <= r_sh[6];
                            r_sh  <= {r_sh[6:0], 1'b0};
                        end
                    end
                end else begin
                    r_cnt <= r_cnt + ONE;
                end
                SSTRAIL: if (r_cnt == DIV_M1) begin
                    r_ss2   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= GAP;
                end else begin
                    r_cnt <= r_cnt + ONE;
                end
                GAP: if (r_cnt == GAP_M1) begin
                    r_cnt <= '0;
                    if (r_phase != 2'd3) begin
                        r_phase <= r_phase + 2'd1;
                        r_bsel  <= 1'b0;
                        r_ss2   <= 1'b0;
                        r_state <= SSLEAD;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end
                end else begin
                    r_cnt <= r_cnt + ONE;
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sent_cnt = r_sent_cnt;
    assign spi_sck  = r_sck;
    assign spi_ss2  = r_ss2;
    assign spi_di   = r_di;
endmodule

// File: tb/tb_jtframe_mist_spi_tx.sv
// Bench for jtframe_mist_spi_tx: passive SPI decoder with timing checks, a
// stalling byte source and an expected-MOSI-byte queue fed at start time.
module tb_jtframe_mist_spi_tx;
    localparam int CLKDIV = 4;
    localparam int SS_GAP = 8;

    logic        clk, rst_n, start, byte_valid, byte_ready, busy, done;
    logic        spi_sck, spi_ss2, spi_di;
    logic [7:0]  index, byte_data;
    logic [25:0] len, sent_cnt;

    jtframe_mist_spi_tx #(.CLKDIV(CLKDIV), .SS_GAP(SS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .index(index), .len(len),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done), .sent_cnt(sent_cnt),
        .spi_sck(spi_sck), .spi_ss2(spi_ss2), .spi_di(spi_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  index;
        logic [25:0] len;
        bit          fixed;
        int          stall_at;
        int          stall;
        logic [25:0] exp_sent;
        int          exp_ready;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        int         stall;
    } src_t;

    int   n_chk = 0, n_fail = 0;
    int   n_rise = 0, n_ssfall = 0, n_done = 0, n_ready = 0;
    bit   chk_low = 1'b1;
    logic [7:0] exp_q[$];
    src_t src_q[$];
    logic [7:0] fix_b[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // SPI monitor: decodes MOSI on SCK rise and measures SCK/SS timing in clk cycles
    logic [7:0] m_sh;
    int   m_nb, m_lo, m_hi, m_gap;
    bit   m_psck, m_pss, m_seen_rel, m_first;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_nb = 0; m_lo = 0; m_hi = 0; m_gap = 0;
            m_psck = 1'b0; m_pss = 1'b1; m_seen_rel = 1'b0; m_first = 1'b0;
        end else begin
            if (done) begin
                n_done++;
                if (m_seen_rel) chk("fin_gap", 32'(m_gap), 32'(SS_GAP));
                m_seen_rel = 1'b0;
            end
            if (byte_ready) n_ready++;
            if (spi_ss2 && !m_pss) begin
                chk("ss_trail", 32'(m_lo), 32'(CLKDIV));
                chk("byte_align", 32'(m_nb), 32'd0);
                m_seen_rel = 1'b1;
                m_gap = 0;
            end
            if (!spi_ss2 && m_pss) begin
                n_ssfall++;
                if (m_seen_rel) chk("ss_gap", 32'(m_gap), 32'(SS_GAP));
                m_first = 1'b1; m_lo = 0; m_nb = 0;
            end
            if (spi_ss2) m_gap++;
            if (!spi_ss2) begin
                if (spi_sck && !m_psck) begin
                    n_rise++;
                    if (m_first) chk("ss_lead", 32'(m_lo), 32'(CLKDIV));
                    else if (chk_low) chk("sck_lo", 32'(m_lo), 32'(CLKDIV));
                    m_first = 1'b0; m_lo = 0; m_hi = 0;
                    m_sh = {m_sh[6:0], spi_di};
                    m_nb++;
                    if (m_nb == 8) begin
                        m_nb = 0;
                        if (exp_q.size() == 0) chk("mosi_extra", 32'(m_sh), 32'hFFFF_FFFF);
                        else chk("mosi", 32'(m_sh), 32'(exp_q.pop_front()));
                    end
                end
                if (!spi_sck && m_psck) chk("sck_hi", 32'(m_hi), 32'(CLKDIV));
                if (spi_sck) m_hi++; else m_lo++;
            end
            m_psck = spi_sck;
            m_pss  = spi_ss2;
        end
    end

    // byte source: one byte in flight, optional hold-off before presenting it
    src_t s_pend;
    bit   s_have, s_took;
    int   s_sc;
    initial begin
        byte_valid = 1'b0; byte_data = 8'h00;
        s_have = 1'b0; s_took = 1'b0; s_sc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                src_q.delete();
                s_have = 1'b0; s_took = 1'b0; s_sc = 0; byte_valid = 1'b0;
            end else begin
                if (s_took) begin
                    s_took = 1'b0; byte_valid = 1'b0;
                end else if (byte_ready) begin
                    s_took = 1'b1;
                end
                if (!byte_valid && !s_took) begin
                    if (!s_have && src_q.size() > 0) begin
                        s_pend = src_q.pop_front(); s_have = 1'b1; s_sc = s_pend.stall;
                    end
                    if (s_have) begin
                        if (s_sc == 0) begin
                            byte_data = s_pend.d; byte_valid = 1'b1; s_have = 1'b0;
                        end else begin
                            s_sc--;
                        end
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input bit mid_start, input bit on_done, input bit abort);
        int r0, s0, d0, q0, nbytes;
        bit got;
        logic [7:0] b;
        chk_low = (v.stall == 0);
        exp_q.push_back(8'h55); exp_q.push_back(v.index);
        exp_q.push_back(8'h53); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h54);
        for (int i = 0; i < int'(v.len); i++) begin
            b = v.fixed ? fix_b[i % 4] : 8'($urandom);
            src_q.push_back('{d: b, stall: (i == v.stall_at) ? v.stall : 0});
            exp_q.push_back(b);
        end
        exp_q.push_back(8'h53); exp_q.push_back(8'h00);
        nbytes = 7 + int'(v.len);
        @(negedge clk);
        r0 = n_rise; s0 = n_ssfall; d0 = n_done; q0 = n_ready;
        index = v.index; len = v.len; start = 1'b1;
        @(negedge clk);
        start = 1'b0; index = 8'($urandom); len = 26'h3FF_FFFF;
        chk("busy_after_start", 32'(busy), 32'd1);
        got = 1'b0;
        if (abort) begin
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (sent_cnt == 26'd1) begin got = 1'b1; break; end
            end
            chk("abort_reach", 32'(got), 32'd1);
            repeat (6) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("abort_ss2", 32'(spi_ss2), 32'd1);
            chk("abort_sck", 32'(spi_sck), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_ready", 32'(byte_ready), 32'd0);
            chk("abort_sent", 32'(sent_cnt), 32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (mid_start && c == 100) begin
                    start = 1'b1; index = 8'hEE; len = 26'd9;
                    @(negedge clk);
                    start = 1'b0;
                end
                if (done) begin
                    got = 1'b1;
                    if (on_done) start = 1'b1;
                    break;
                end
            end
            chk("done_seen", 32'(got), 32'd1);
            @(negedge clk);
            start = 1'b0;
            repeat (3 * SS_GAP) @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ss2", 32'(spi_ss2), 32'd1);
            chk("sent_cnt", 32'(sent_cnt), 32'(v.exp_sent));
            chk("ready_pulses", 32'(n_ready - q0), 32'(v.exp_ready));
            chk("done_pulses", 32'(n_done - d0), 32'd1);
            chk("ss_trans", 32'(n_ssfall - s0), 32'd4);
            chk("sck_rises", 32'(n_rise - r0), 32'(8 * nbytes));
            chk("mosi_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    vec_t vecs[5];
    vec_t hv;
    initial begin
        fix_b[0] = 8'hA1; fix_b[1] = 8'hB2; fix_b[2] = 8'hC3; fix_b[3] = 8'hD4;
        //          index  len     fixed stall_at stall exp_sent exp_ready
        vecs[0] = '{8'h00, 26'd4, 1'b1, -1,  0, 26'd4, 4};
        vecs[1] = '{8'hFF, 26'd0, 1'b0, -1,  0, 26'd0, 0};
        vecs[2] = '{8'h3C, 26'd4, 1'b1,  2, 50, 26'd4, 4};
        vecs[3] = '{8'h81, 26'd1, 1'b0, -1,  0, 26'd1, 1};
        vecs[4] = '{8'h5A, 26'd7, 1'b0,  3, 40, 26'd7, 7};

        rst_n = 1'b0; start = 1'b0; index = 8'h00; len = 26'd0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_ss2", 32'(spi_ss2), 32'd1);
        chk("rst_di", 32'(spi_di), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_sent", 32'(sent_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0, 1'b0, 1'b0);

        // start while busy and start on the done cycle are both ignored
        hv = '{8'h42, 26'd2, 1'b0, -1, 0, 26'd2, 2};
        run_vec(hv, 1'b1, 1'b1, 1'b0);

        // reset mid-payload, then a clean full sequence from the index phase
        run_vec(vecs[0], 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        run_vec(vecs[0], 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
